// File: rtl/lzs_token_parser_if.sv
// Bit-window and command channels of the LZS token parser.
// Latency: none (signal bundles only).
// Backpressure: stream side is ack-driven by the consumer; cmd side is valid/ready.
//
// lzs_stream_if: master = bit aligner (drives window), slave = parser (acks bits).
// lzs_cmd_if:    master = parser (drives commands), slave = copy engine (ready).

interface lzs_stream_if #(
  parameter int IN_WIDTH = 13
);
  localparam int BITS_W = $clog2(IN_WIDTH + 1);

  logic [IN_WIDTH-1:0] stream_data;   // left-justified window, MSB first
  logic [BITS_W-1:0]   stream_bits;   // number of valid bits in the window
  logic                stream_ack;    // consume stream_width bits this edge
  logic [3:0]          stream_width;  // bits consumed when acked

  modport master (
    output stream_data, stream_bits,
    input  stream_ack, stream_width
  );

  modport slave (
    input  stream_data, stream_bits,
    output stream_ack, stream_width
  );
endinterface

interface lzs_cmd_if #(
  parameter int OFFSET_WIDTH = 12,
  parameter int LENGTH_WIDTH = 16
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [1:0]              cmd_kind;     // 00 literal, 01 copy, 10 end-of-block
  logic [7:0]              cmd_literal;
  logic [OFFSET_WIDTH-1:0] cmd_offset;
  logic [LENGTH_WIDTH-1:0] cmd_length;

  modport master (
    output cmd_valid, cmd_kind, cmd_literal, cmd_offset, cmd_length,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_kind, cmd_literal, cmd_offset, cmd_length,
    output cmd_ready
  );
endinterface

// File: rtl/lzs_token_parser.sv
// LZS token parser: turns a left-justified bit window into literal/copy/end commands.
// Latency: ack is combinational; the command appears 1 cycle after its final consume.
// Backpressure: command-emitting consumes wait for a free slot; the window is not acked meanwhile.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             pulse, leaves IDLE and begins parsing
//   stream (slave)    bit window in, ack/width out
//   cmd (master)      one command per literal, copy or end marker
//   done              sticky, final end marker seen (MULTI_BLOCK=0 only)
//   err_offset        sticky, long-form offset of zero seen
//   err_len_ovf       sticky, copy length saturated

module lzs_token_parser #(
  parameter int IN_WIDTH     = 13,
  parameter int OFFSET_WIDTH = 12,
  parameter int LENGTH_WIDTH = 16,
  parameter int MULTI_BLOCK  = 0
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      start,
  lzs_stream_if.slave stream,
  lzs_cmd_if.master   cmd,
  output logic      done,
  output logic      err_offset,
  output logic      err_len_ovf
);

  localparam int BITS_W = $clog2(IN_WIDTH + 1);

  localparam logic [1:0] KIND_LIT  = 2'b00;
  localparam logic [1:0] KIND_COPY = 2'b01;
  localparam logic [1:0] KIND_END  = 2'b10;

  localparam logic [LENGTH_WIDTH-1:0] LEN_MAX = {LENGTH_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TOKEN,
    ST_LEN,
    ST_LENX,
    ST_ALIGN,
    ST_DONE
  } state_t;

  state_t state_q, state_d;

  // Registered datapath
  logic [2:0]              bitpos_q;
  logic [LENGTH_WIDTH-1:0] acc_q;
  logic [OFFSET_WIDTH-1:0] off_q;
  logic                    vld_q;
  logic [1:0]              kind_q;
  logic [7:0]              lit_q;
  logic [OFFSET_WIDTH-1:0] cmd_off_q;
  logic [LENGTH_WIDTH-1:0] len_q;
  logic                    err_off_q;
  logic                    err_ovf_q;

  // Decode controls from the next-state process
  logic                    ack;
  logic [3:0]              width;
  logic                    emit;
  logic [1:0]              emit_kind;
  logic [7:0]              emit_lit;
  logic [LENGTH_WIDTH-1:0] emit_len;
  logic                    off_ld;
  logic [OFFSET_WIDTH-1:0] off_d;
  logic                    acc_clr;
  logic                    acc_ld;
  logic [LENGTH_WIDTH-1:0] acc_d;
  logic                    bitpos_clr;
  logic                    set_err_off;
  logic                    set_ovf;

  // The first 13 window bits hold every field the parser ever needs.
  logic [12:0] t;
  assign t = stream.stream_data[IN_WIDTH-1 -: 13];

  logic has2, has4, has9, has13, has_pad;
  logic [2:0] pad;
  assign pad     = 3'd0 - bitpos_q;  // (8 - bitpos) mod 8
  assign has2    = stream.stream_bits >= BITS_W'(2);
  assign has4    = stream.stream_bits >= BITS_W'(4);
  assign has9    = stream.stream_bits >= BITS_W'(9);
  assign has13   = stream.stream_bits >= BITS_W'(13);
  assign has_pad = stream.stream_bits >= BITS_W'(pad);

  logic slot_free;
  assign slot_free = !vld_q || cmd.cmd_ready;

  // One extra bit catches the carry that signals saturation.
  logic [LENGTH_WIDTH:0] sum_ext, sum_fin;
  assign sum_ext = {1'b0, acc_q} + (LENGTH_WIDTH+1)'(15);
  assign sum_fin = {1'b0, acc_q} + (LENGTH_WIDTH+1)'(t[12:9]) + (LENGTH_WIDTH+1)'(8);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ack         = 1'b0;
    width       = 4'd0;
    emit        = 1'b0;
    emit_kind   = KIND_LIT;
    emit_lit    = 8'h00;
    emit_len    = '0;
    off_ld      = 1'b0;
    off_d       = '0;
    acc_clr     = 1'b0;
    acc_ld      = 1'b0;
    acc_d       = acc_q;
    bitpos_clr  = 1'b0;
    set_err_off = 1'b0;
    set_ovf     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_TOKEN;
          bitpos_clr = 1'b1;
          acc_clr    = 1'b1;
        end
      end

      ST_TOKEN: begin
        if (has2) begin
          if (!t[12]) begin
            // Literal: flag 0 + 8 data bits
            if (has9 && slot_free) begin
              ack       = 1'b1;
              width     = 4'd9;
              emit      = 1'b1;
              emit_kind = KIND_LIT;
              emit_lit  = t[11:4];
            end
          end else if (!t[11]) begin
            // Long offset: 10 + 11 bits; no command yet, so no slot needed
            if (has13) begin
              ack         = 1'b1;
              width       = 4'd13;
              off_ld      = 1'b1;
              off_d       = OFFSET_WIDTH'(t[10:0]);
              set_err_off = (t[10:0] == 11'd0);
              state_d     = ST_LEN;
            end
          end else if (has9) begin
            if (t[10:4] != 7'd0) begin
              // Short offset: 11 + 7 bits
              ack     = 1'b1;
              width   = 4'd9;
              off_ld  = 1'b1;
              off_d   = OFFSET_WIDTH'(t[10:4]);
              state_d = ST_LEN;
            end else if (slot_free) begin
              // End marker: short form with a zero offset
              ack       = 1'b1;
              width     = 4'd9;
              emit      = 1'b1;
              emit_kind = KIND_END;
              state_d   = (MULTI_BLOCK != 0) ? ST_ALIGN : ST_DONE;
            end
          end
        end
      end

      ST_LEN: begin
        if (has2) begin
          if (t[12:11] != 2'b11) begin
            if (slot_free) begin
              ack       = 1'b1;
              width     = 4'd2;
              emit      = 1'b1;
              emit_kind = KIND_COPY;
              emit_len  = LENGTH_WIDTH'(t[12:11]) + LENGTH_WIDTH'(2);
              state_d   = ST_TOKEN;
            end
          end else if (has4) begin
            if (t[10:9] == 2'b11) begin
              // 1111 escapes into the extended-length nibble chain
              ack     = 1'b1;
              width   = 4'd4;
              acc_clr = 1'b1;
              state_d = ST_LENX;
            end else if (slot_free) begin
              ack       = 1'b1;
              width     = 4'd4;
              emit      = 1'b1;
              emit_kind = KIND_COPY;
              emit_len  = LENGTH_WIDTH'(t[10:9]) + LENGTH_WIDTH'(5);
              state_d   = ST_TOKEN;
            end
          end
        end
      end

      ST_LENX: begin
        if (has4) begin
          if (t[12:9] == 4'hF) begin
            ack     = 1'b1;
            width   = 4'd4;
            acc_ld  = 1'b1;
            acc_d   = sum_ext[LENGTH_WIDTH] ? LEN_MAX : sum_ext[LENGTH_WIDTH-1:0];
            set_ovf = sum_ext[LENGTH_WIDTH];
          end else if (slot_free) begin
            ack       = 1'b1;
            width     = 4'd4;
            emit      = 1'b1;
            emit_kind = KIND_COPY;
            emit_len  = sum_fin[LENGTH_WIDTH] ? LEN_MAX : sum_fin[LENGTH_WIDTH-1:0];
            set_ovf   = sum_fin[LENGTH_WIDTH];
            acc_clr   = 1'b1;
            state_d   = ST_TOKEN;
          end
        end
      end

      ST_ALIGN: begin
        // bitpos already includes the end marker; skip to the next byte boundary
        if (pad == 3'd0) begin
          state_d = ST_TOKEN;
        end else if (has_pad) begin
          ack     = 1'b1;
          width   = {1'b0, pad};
          state_d = ST_TOKEN;
        end
      end

      ST_DONE: begin
        state_d = ST_DONE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Bit position, length accumulator, latched offset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitpos_q <= 3'd0;
      acc_q    <= '0;
      off_q    <= '0;
    end else begin
      if (bitpos_clr)  bitpos_q <= 3'd0;
      else if (ack)    bitpos_q <= 3'({1'b0, bitpos_q} + width);
      if (acc_clr)     acc_q <= '0;
      else if (acc_ld) acc_q <= acc_d;
      if (off_ld)      off_q <= off_d;
    end
  end

  // Command slot: loads on an emitting consume, holds while not accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q     <= 1'b0;
      kind_q    <= KIND_LIT;
      lit_q     <= 8'h00;
      cmd_off_q <= '0;
      len_q     <= '0;
    end else if (emit) begin
      vld_q     <= 1'b1;
      kind_q    <= emit_kind;
      lit_q     <= emit_lit;
      cmd_off_q <= (emit_kind == KIND_COPY) ? off_q : '0;
      len_q     <= emit_len;
    end else if (cmd.cmd_ready) begin
      vld_q <= 1'b0;
    end
  end

  // Sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_off_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      if (set_err_off) err_off_q <= 1'b1;
      if (set_ovf)     err_ovf_q <= 1'b1;
    end
  end

  assign stream.stream_ack   = ack;
  assign stream.stream_width = width;

  assign cmd.cmd_valid   = vld_q;
  assign cmd.cmd_kind    = kind_q;
  assign cmd.cmd_literal = lit_q;
  assign cmd.cmd_offset  = cmd_off_q;
  assign cmd.cmd_length  = len_q;

  assign done        = (state_q == ST_DONE);
  assign err_offset  = err_off_q;
  assign err_len_ovf = err_ovf_q;

endmodule

// File: tb/tb_lzs_token_parser.sv
// Directed bench for lzs_token_parser: one single-block DUT (defaults) and one
// multi-block DUT with a 6-bit length field, driven by the same stimulus.
module tb_lzs_token_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cr;
  logic [12:0] sd;
  logic [3:0]  bits;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lzs_stream_if #(.IN_WIDTH(13)) s_a ();
  lzs_stream_if #(.IN_WIDTH(13)) s_b ();
  lzs_cmd_if #(.OFFSET_WIDTH(12), .LENGTH_WIDTH(16)) c_a ();
  lzs_cmd_if #(.OFFSET_WIDTH(12), .LENGTH_WIDTH(6))  c_b ();

  assign s_a.stream_data = sd;
  assign s_a.stream_bits = bits;
  assign s_b.stream_data = sd;
  assign s_b.stream_bits = bits;
  assign c_a.cmd_ready   = cr;
  assign c_b.cmd_ready   = cr;

  logic done_a, eo_a, el_a;
  logic done_b, eo_b, el_b;

  lzs_token_parser #(
    .IN_WIDTH(13), .OFFSET_WIDTH(12), .LENGTH_WIDTH(16), .MULTI_BLOCK(0)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start),
    .stream(s_a), .cmd(c_a),
    .done(done_a), .err_offset(eo_a), .err_len_ovf(el_a)
  );

  lzs_token_parser #(
    .IN_WIDTH(13), .OFFSET_WIDTH(12), .LENGTH_WIDTH(6), .MULTI_BLOCK(1)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start),
    .stream(s_b), .cmd(c_b),
    .done(done_b), .err_offset(eo_b), .err_len_ovf(el_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present n bits (low bits of v) left-justified in the window.
  task automatic put(input logic [12:0] v, input int n);
    sd   = v << (13 - n);
    bits = 4'(n);
    #1;
  endtask

  task automatic step_a(input string tag, input logic [12:0] v, input int n, input int w);
    put(v, n);
    chk({tag, ".ack"}, 32'(s_a.stream_ack), 32'(w != 0));
    chk({tag, ".width"}, 32'(s_a.stream_width), 32'(w));
    tick();
  endtask

  task automatic step_b(input string tag, input logic [12:0] v, input int n, input int w);
    put(v, n);
    chk({tag, ".ack"}, 32'(s_b.stream_ack), 32'(w != 0));
    chk({tag, ".width"}, 32'(s_b.stream_width), 32'(w));
    tick();
  endtask

  task automatic chk_cmd_a(input string tag, input logic [1:0] kind, input logic [7:0] lit,
                           input logic [11:0] off, input logic [15:0] len);
    chk({tag, ".valid"}, 32'(c_a.cmd_valid), 32'd1);
    chk({tag, ".kind"}, 32'(c_a.cmd_kind), 32'(kind));
    if (kind == 2'b00) chk({tag, ".literal"}, 32'(c_a.cmd_literal), 32'(lit));
    if (kind == 2'b01) begin
      chk({tag, ".offset"}, 32'(c_a.cmd_offset), 32'(off));
      chk({tag, ".length"}, 32'(c_a.cmd_length), 32'(len));
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    cr    = 1'b1;
    sd    = '0;
    bits  = '0;
    #12;
    // Reset state
    chk("rst.valid", 32'(c_a.cmd_valid), 32'd0);
    chk("rst.ack", 32'(s_a.stream_ack), 32'd0);
    chk("rst.width", 32'(s_a.stream_width), 32'd0);
    chk("rst.done", 32'(done_a), 32'd0);
    chk("rst.err_offset", 32'(eo_a), 32'd0);
    chk("rst.err_len_ovf", 32'(el_a), 32'd0);
    rst = 1'b0;
    tick();
    // IDLE ignores the window until start
    put(13'b0_01000001_1010, 13);
    chk("idle.ack", 32'(s_a.stream_ack), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;

    // Literal: 8 of 9 bits is not enough, 13 bits consumes exactly 9
    put(13'b0_0100000, 8);
    chk("short.ack", 32'(s_a.stream_ack), 32'd0);
    chk("short.width", 32'(s_a.stream_width), 32'd0);
    step_a("lit41", 13'b0_01000001_1010, 13, 9);
    chk_cmd_a("lit41.cmd", 2'b00, 8'h41, 12'h0, 16'd0);

    // Short offset 5, length code 00 -> length 2
    step_a("off5", 13'b11_0000101, 9, 9);
    chk("off5.valid", 32'(c_a.cmd_valid), 32'd0);
    step_a("len2", 13'b00, 2, 2);
    chk_cmd_a("copy5_2", 2'b01, 8'h0, 12'd5, 16'd2);

    // Long offset 0x400, extended length 1111 0000 -> 8
    step_a("off400", 13'b10_10000000000, 13, 13);
    step_a("len8.n1", 13'b1111, 4, 4);
    step_a("len8.n2", 13'b0000, 4, 4);
    chk_cmd_a("copy400_8", 2'b01, 8'h0, 12'h400, 16'd8);

    // 1111 | 1111 1111 0011 -> 15 + 15 + 3 + 8 = 41
    step_a("off400b", 13'b10_10000000000, 13, 13);
    step_a("len41.n1", 13'b1111, 4, 4);
    step_a("len41.n2", 13'b1111, 4, 4);
    step_a("len41.n3", 13'b1111, 4, 4);
    step_a("len41.n4", 13'b0011, 4, 4);
    chk_cmd_a("copy400_41", 2'b01, 8'h0, 12'h400, 16'd41);

    // Backpressure: copy held for 5 cycles, literal waits without ack
    step_a("off3", 13'b11_0000011, 9, 9);
    cr = 1'b0;
    step_a("len3", 13'b01, 2, 2);
    chk_cmd_a("copy3_3", 2'b01, 8'h0, 12'd3, 16'd3);
    put(13'b0_11111111, 9);
    for (int i = 0; i < 5; i++) begin
      chk("bp.ack", 32'(s_a.stream_ack), 32'd0);
      chk("bp.valid", 32'(c_a.cmd_valid), 32'd1);
      chk("bp.kind", 32'(c_a.cmd_kind), 32'd1);
      chk("bp.length", 32'(c_a.cmd_length), 32'd3);
      tick();
    end
    cr = 1'b1;
    #1;
    chk("bp.rel.ack", 32'(s_a.stream_ack), 32'd1);
    chk("bp.rel.width", 32'(s_a.stream_width), 32'd9);
    tick();
    chk_cmd_a("litFF", 2'b00, 8'hFF, 12'h0, 16'd0);

    // Long-form offset of zero flags an error but still produces a copy
    step_a("off0", 13'b10_00000000000, 13, 13);
    chk("off0.err_offset", 32'(eo_a), 32'd1);
    step_a("len4", 13'b10, 2, 2);
    chk_cmd_a("copy0_4", 2'b01, 8'h0, 12'd0, 16'd4);
    chk("a.err_len_ovf", 32'(el_a), 32'd0);

    // End marker in single-block mode: end command, then DONE with no acks
    step_a("eob_a", 13'b11_0000000, 9, 9);
    chk_cmd_a("eob_a.cmd", 2'b10, 8'h0, 12'h0, 16'd0);
    chk("eob_a.done", 32'(done_a), 32'd1);
    put(13'b0_10101010, 9);
    chk("done.ack", 32'(s_a.stream_ack), 32'd0);
    tick();
    chk("done.ack2", 32'(s_a.stream_ack), 32'd0);
    chk("done.width2", 32'(s_a.stream_width), 32'd0);
    chk("done.sticky", 32'(done_a), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("done.start_ignored", 32'(done_a), 32'd1);

    // Multi-block DUT: restart from reset
    rst = 1'b1;
    #1;
    chk("rst2.done", 32'(done_a), 32'd0);
    chk("rst2.err_offset", 32'(eo_a), 32'd0);
    rst = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;

    // literal (9) + marker (9) leaves bitpos 2, so 6 pad bits follow
    step_b("b.lit", 13'b0_10101010, 9, 9);
    chk("b.lit.kind", 32'(c_b.cmd_kind), 32'd0);
    chk("b.lit.literal", 32'(c_b.cmd_literal), 32'hAA);
    step_b("b.eob", 13'b11_0000000, 9, 9);
    chk("b.eob.valid", 32'(c_b.cmd_valid), 32'd1);
    chk("b.eob.kind", 32'(c_b.cmd_kind), 32'd2);
    chk("b.eob.done", 32'(done_b), 32'd0);
    put(13'b10101, 5);
    chk("b.pad_short.ack", 32'(s_b.stream_ack), 32'd0);
    step_b("b.pad", 13'b101010, 6, 6);
    step_b("b.lit2", 13'b0_00110011, 9, 9);
    chk("b.lit2.kind", 32'(c_b.cmd_kind), 32'd0);
    chk("b.lit2.literal", 32'(c_b.cmd_literal), 32'h33);

    // 6-bit lengths: 1111 | 1111 x4 | 0000 -> 60 + 8 = 68, clamped to 63
    step_b("b.off1", 13'b11_0000001, 9, 9);
    step_b("b.len.esc", 13'b1111, 4, 4);
    for (int i = 0; i < 4; i++) step_b("b.len.f", 13'b1111, 4, 4);
    chk("b.pre.err_len_ovf", 32'(el_b), 32'd0);
    step_b("b.len.last", 13'b0000, 4, 4);
    chk("b.sat.kind", 32'(c_b.cmd_kind), 32'd1);
    chk("b.sat.offset", 32'(c_b.cmd_offset), 32'd1);
    chk("b.sat.length", 32'(c_b.cmd_length), 32'd63);
    chk("b.sat.err_len_ovf", 32'(el_b), 32'd1);

    // Reset while a command is pending drops it immediately
    cr = 1'b0;
    tick();
    chk("b.hold.valid", 32'(c_b.cmd_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("b.rst.valid", 32'(c_b.cmd_valid), 32'd0);
    chk("b.rst.err_len_ovf", 32'(el_b), 32'd0);
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lzs_token_parser.md
# lzs_token_parser

Parametrised LZS token parser feeding the copy engine. It sits between the bit aligner, which presents a left-justified bit window, and the history/copy engine. Each literal, copy (offset plus fully accumulated length) or end marker leaves as one command on a valid/ready interface, so the copy engine needs no per-nibble handshakes. It adds byte-aligned multi-block streams, length saturation and error flags.

## Interface
- IN_WIDTH, 13: bit-window width; must be ≥13. Fields are read MSB-first from stream_data[IN_WIDTH-1].
- OFFSET_WIDTH, 12: command offset width; must be ≥11. Offsets are zero-extended.
- LENGTH_WIDTH, 16: command length width; must be ≥4.
- MULTI_BLOCK, 0: 0 = stop at the first end marker; 1 = byte-align after each end marker and continue.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  pulse; leaves IDLE.
- stream_data  in  IN_WIDTH  bit window, MSB = next unconsumed bit.
- stream_bits  in  ceil(log2(IN_WIDTH+1))  number of valid bits in the window.
- stream_ack  out  1  combinational; consumes stream_width bits at this clock edge.
- stream_width  out  4  bits consumed when stream_ack is high (0..13).
- cmd_valid  out  1  command held.
- cmd_ready  in  1  downstream accepts.
- cmd_kind  out  2  00 literal, 01 copy, 10 end-of-block.
- cmd_literal  out  8  literal byte.
- cmd_offset  out  OFFSET_WIDTH  copy offset.
- cmd_length  out  LENGTH_WIDTH  copy length.
- done  out  1  sticky; final end marker seen (only when MULTI_BLOCK=0).
- err_offset  out  1  sticky; long-form offset of 0 seen.
- err_len_ovf  out  1  sticky; length saturated.

## Operation
- States: IDLE, TOKEN, LEN, LENX, ALIGN, DONE.
- IDLE → TOKEN on start. start is ignored in every other state. Entering TOKEN from IDLE clears the bit-position counter bitpos[2:0] and the length accumulator acc.
- On every ack, bitpos += stream_width (mod 8).
- slot_free = !cmd_valid || cmd_ready.
- A consume that emits a command (literal, final length, end marker) also requires slot_free. Offset and 1111-nibble consumes do not.
- TOKEN: stall while stream_bits < 2.
  - Prefix 0 needs 9 bits: emit literal = bits[7:0] after the flag. Stay in TOKEN.
  - Prefix 10 needs 13 bits: latch the 11-bit offset; → LEN. If the offset is 0, set err_offset and continue.
  - Prefix 11 needs 9 bits. Next 7 bits nonzero: latch the 7-bit offset; → LEN. All zero: end marker; emit end-of-block.
    - MULTI_BLOCK=0: → DONE.
    - MULTI_BLOCK=1: → ALIGN.
- LEN: stall while stream_bits < 2.
  - 00/01/10 (2 bits): emit copy with length 2/3/4; → TOKEN.
  - 11 needs 4 bits. 1100/1101/1110: emit copy with length 5/6/7; → TOKEN. 1111: acc = 0; → LENX.
- LENX: needs 4 bits.
  - 1111: acc = sat(acc+15); stay.
  - Otherwise nibble n: emit copy with length sat(acc+n+8); → TOKEN; acc cleared.
  - sat() clamps at 2^LENGTH_WIDTH-1. Any clamp sets err_len_ovf.
- ALIGN: pad = (8-bitpos) mod 8, where bitpos already includes the marker.
  - pad = 0: → TOKEN with no ack.
  - Otherwise: wait for stream_bits ≥ pad, ack pad bits, → TOKEN. Pad contents are ignored.
- DONE: no ack; done = 1. Only rst leaves DONE.
- Insufficient bits never produce a partial consume. stream_width = 0 whenever stream_ack = 0.

## Timing
- Reset values: all outputs 0, state IDLE, bitpos 0, acc 0.
- stream_ack and stream_width are Mealy outputs of the current state, stream_data, stream_bits and slot_free. No registered delay.
- Command registers load at the consuming edge, so cmd_valid rises 1 cycle after the ack.
- cmd_* hold stable while cmd_valid && !cmd_ready.
- cmd_valid clears on accept unless a new command loads at the same edge (back-to-back).
- Throughput:
  - literal: 1 per cycle;
  - copy with length ≤7: 2 cycles;
  - extended copy: 3+k cycles (k = number of 1111 nibbles).
- Sticky flags and done clear only on rst. rst mid-command drops cmd_valid at once.

## Test plan
- Window 0_01000001, bits=13, cmd_ready=1 → ack width 9; next cycle cmd_valid, kind 00, literal 0x41; state TOKEN.
- 11_0000101 then 00 → ack 9, then ack 2; cmd copy, offset 5, length 2.
- 10_10000000000 then 1111, 0000 → acks 13, 4, 4; copy offset 0x400, length 8. Same with 1111,1111,0011 → length 41.
- Copy command pending with cmd_ready=0 for 5 cycles, next token a literal → no ack for 5 cycles; cmd_* stable; literal emitted the cycle after cmd_ready rises.
- MULTI_BLOCK=1: literal (9 bits) + end marker (9 bits) → bitpos=2, pad 6 acked; kind 10 emitted; next literal parsed. MULTI_BLOCK=0: done=1 and ack stays 0.
- LENGTH_WIDTH=6: length nibbles 11,1111×4,0000 → cmd_length 63, err_len_ovf=1. Long offset 0 → err_offset=1, copy still emitted.
